// File: rtl/req_queue_if.sv
// Requester/arbiter-facing bundle of one request queue.
// The slave side is the queue; the master side is the requester plus the arbiter stall.
interface req_queue_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             in_stall;
  logic [CW-1:0]    out_count;
  logic             out_overflow;
  logic             out_starved;

  modport slave (
    input  in_valid, in_data, in_stall,
    output out_full, out_valid, out_data, out_count, out_overflow, out_starved
  );

  modport master (
    output in_valid, in_data, in_stall,
    input  out_full, out_valid, out_data, out_count, out_overflow, out_starved
  );
endinterface

// File: rtl/req_queue.sv
// Per-requester FIFO feeding one arbiter input.
// Sticky overflow on a dropped write; starvation flag when the head is stalled too long.
module req_queue #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  req_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             starved_q, starved_d;
  logic             valid, full, push, pop;

  // Status comes from registers only, so nothing from the inputs reaches the outputs.
  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  assign q.out_valid    = valid;
  assign q.out_full     = full;
  assign q.out_data     = valid ? mem_q[rd_ptr_q] : '0;
  assign q.out_count    = count_q;
  assign q.out_overflow = ovf_q;
  assign q.out_starved  = starved_q;

  // A full queue rejects writes even when the head pops this cycle.
  always_comb begin
    push     = q.in_valid && !full;
    pop      = valid && !q.in_stall;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (q.in_valid & full);
    if (valid && q.in_stall)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    else
      starve_d = '0;
    starved_d = (starve_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      starve_q  <= '0;
      starved_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      starve_q  <= starve_d;
      starved_q <= starved_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= q.in_data;
  end
endmodule
